// File: rtl/scb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scb_pkg
// Description : Shared constants, state type and packing helper for the
//               multiplier result unloader.  SCB_ROUND_P_EN selects the
//               rounded 10-bit packing.
// Revision    : 1.0
// ============================================================================
package scb_pkg;

    localparam int N_COEF     = 256;
    localparam int COEF_W     = 13;
    localparam int P_W        = 10;
    localparam int ROUND_H    = 4;
    localparam int WORD_W_DEF = 64;

    localparam int NWORDS_RAW = (N_COEF * COEF_W) / WORD_W_DEF;
    localparam int NWORDS_RND = (N_COEF * P_W) / WORD_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of the packed capture vector for a given coefficient layout.
    function automatic int pack_width(input int n_coef, input int coef_w, input bit rounded);
        return rounded ? n_coef * P_W : n_coef * coef_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scb_result_unloader_pack.sv
`default_nettype none
// ============================================================================
// Module      : scb_coef_pack
// Description : Combinational packer: raw coefficients, or coefficients
//               rounded to P_W bits when SCB_ROUND_P_EN is defined.
// Revision    : 1.0
// ============================================================================
module scb_coef_pack #(
    parameter int N_COEF = 256,
    parameter int COEF_W = 13,
    parameter int OUT_W  = N_COEF * COEF_W
) (
    input  logic [N_COEF*COEF_W-1:0] i_result,
    output logic [OUT_W-1:0]         o_packed
);
    import scb_pkg::*;

`ifdef SCB_ROUND_P_EN
    // The +ROUND_H sum is kept at COEF_W bits so it wraps like the datapath.
    for (genvar i = 0; i < N_COEF; i++) begin : g_round
        logic [COEF_W-1:0] w_sum;
        assign w_sum                   = i_result[i*COEF_W +: COEF_W] + COEF_W'(ROUND_H);
        assign o_packed[i*P_W +: P_W]  = w_sum[COEF_W-1 -: P_W];
    end
`else
    if (1) begin : g_raw
        assign o_packed = i_result;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/scb_result_unloader.sv
`default_nettype none
// ============================================================================
// Module      : scb_result_unloader
// Description : Captures the multiplier accumulator on a rising mul_done and
//               streams it as WORD_W words into a result BRAM write port.
//               Optional macro SCB_ROUND_P_EN: rounded 10-bit packing.
// Revision    : 1.0
// ============================================================================
module scb_result_unloader #(
    parameter int N_COEF    = 256,
    parameter int COEF_W    = 13,
    parameter int WORD_W    = 64,
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mul_done,
    input  logic [N_COEF*COEF_W-1:0] mul_result,
    input  logic                     mem_ready,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [WORD_W-1:0]        mem_wdata,
    output logic                     busy,
    output logic                     unload_done
);
    import scb_pkg::*;

`ifdef SCB_ROUND_P_EN
    localparam bit c_round = 1'b1;
`else
    localparam bit c_round = 1'b0;
`endif
    localparam int                 c_pack_w = pack_width(N_COEF, COEF_W, c_round);
    localparam int                 c_nwords = c_pack_w / WORD_W;
    localparam int                 c_cnt_w  = (c_nwords > 1) ? $clog2(c_nwords) : 1;
    localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(c_nwords - 1);
    localparam logic [ADDR_W-1:0]  c_base   = ADDR_W'(BASE_ADDR);

    state_t              r_state;
    state_t              w_next;
    logic [c_pack_w-1:0] r_shift;
    logic [c_pack_w-1:0] w_packed;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_mul_done_q;
    logic                r_armed;
    logic                w_trigger;
    logic                w_accept;

    scb_coef_pack #(
        .N_COEF (N_COEF),
        .COEF_W (COEF_W),
        .OUT_W  (c_pack_w)
    ) u_pack (
        .i_result (mul_result),
        .o_packed (w_packed)
    );

    // r_armed blocks a level that was already high when reset released.
    assign w_trigger = mul_done & ~r_mul_done_q & r_armed;
    assign w_accept  = (r_state == WRITE) & mem_ready;
    assign mem_wdata = r_shift[WORD_W-1:0];
    assign mem_addr  = c_base + ADDR_W'(r_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_mul_done_q <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_mul_done_q <= mul_done;
            if (!mul_done) begin
                r_armed <= 1'b1;
            end
            if ((r_state == IDLE) && w_trigger) begin
                r_shift <= w_packed;
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_shift <= r_shift >> WORD_W;
                r_cnt   <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        mem_we      = 1'b0;
        busy        = 1'b0;
        unload_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                if (mem_ready && (r_cnt == c_last)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                unload_done = 1'b1;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

`ifndef SYNTHESIS
    // The address window must fit without wrapping onto earlier words.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (BASE_ADDR + c_nwords <= (1 << ADDR_W))
                else $error("scb_result_unloader: BASE_ADDR + NWORDS exceeds address space");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_scb_result_unloader.sv
`default_nettype none
// ============================================================================
// Module      : tb_scb_result_unloader
// Description : Self-checking bench for scb_result_unloader; follows the
//               SCB_ROUND_P_EN build selection of the design.
// Revision    : 1.0
// ============================================================================
module tb_scb_result_unloader;

    localparam int NC = 256;
    localparam int CW = 13;
    localparam int WW = 64;
    localparam int AW = 6;
`ifdef SCB_ROUND_P_EN
    localparam int FW  = 10;
    localparam bit RND = 1'b1;
`else
    localparam int FW  = 13;
    localparam bit RND = 1'b0;
`endif
    localparam int NW = NC * FW / WW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             mul_done = 1'b0;
    logic [NC*CW-1:0] mul_result = '0;
    logic             mem_ready = 1'b1;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WW-1:0]    mem_wdata;
    logic             busy;
    logic             unload_done;

    int               checks = 0;
    int               errors = 0;
    int unsigned      coef [NC];
    logic [WW-1:0]    exp_w [NW];

    scb_result_unloader #(
        .N_COEF    (NC),
        .COEF_W    (CW),
        .WORD_W    (WW),
        .ADDR_W    (AW),
        .BASE_ADDR (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mul_done    (mul_done),
        .mul_result  (mul_result),
        .mem_ready   (mem_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .unload_done (unload_done)
    );

    always #5 clk = ~clk;

    function automatic int unsigned field_val(input int unsigned c);
        return RND ? ((c + 4) % 8192) / 8 : c;
    endfunction

    // Golden words: bit g of the packed stream belongs to coefficient g/FW.
    task automatic build_model();
        for (int w = 0; w < NW; w++) begin
            for (int b = 0; b < WW; b++) begin
                int          g;
                int unsigned v;
                g = w * WW + b;
                v = field_val(coef[g / FW]);
                exp_w[w][b] = 1'((v >> (g % FW)) & 1);
            end
        end
        for (int i = 0; i < NC; i++) begin
            mul_result[i*CW +: CW] = CW'(coef[i]);
        end
    endtask

    task automatic check(input string name, input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] expv);
        checks++;
        assert (obs === expv)
            else begin
                errors++;
                $error("FAIL %s.%s observed=%0h expected=%0h", name, tag, obs, expv);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic unload(input string name, input int stall_word, input int stall_len,
                          input int glitch_cyc, input int rst_word);
        int idx;
        int cyc;
        int stalled;
        bit rdy;
        build_model();
        mul_done = 1'b0;
        tick();
        mul_done = 1'b1;
        tick();
        mul_result = ~mul_result;
        idx     = 0;
        cyc     = 1;
        stalled = 0;
        while (idx < NW && cyc < NW + stall_len + 20) begin
            check(name, "we",   64'(mem_we), 64'd1);
            check(name, "addr", 64'(mem_addr), 64'(idx % (1 << AW)));
            check(name, "data", mem_wdata, exp_w[idx]);
            check(name, "busy", 64'(busy), 64'd1);
            check(name, "done_early", 64'(unload_done), 64'd0);
            if (idx == rst_word) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check(name, "we_after_rst",   64'(mem_we), 64'd0);
                check(name, "busy_after_rst", 64'(busy), 64'd0);
                return;
            end
            if (cyc == glitch_cyc) mul_done = 1'b0;
            else if (cyc == glitch_cyc + 1) mul_done = 1'b1;
            rdy = !(idx == stall_word && stalled < stall_len);
            if (!rdy) stalled++;
            mem_ready = rdy;
            tick();
            cyc++;
            if (rdy) idx++;
        end
        mem_ready = 1'b1;
        check(name, "words_written", 64'(idx), 64'(NW));
        check(name, "done_latency",  64'(cyc), 64'(NW + stall_len + 1));
        check(name, "done_pulse",    64'(unload_done), 64'd1);
        check(name, "we_in_done",    64'(mem_we), 64'd0);
        check(name, "busy_in_done",  64'(busy), 64'd0);
        tick();
        check(name, "done_cleared",  64'(unload_done), 64'd0);
        check(name, "we_idle",       64'(mem_we), 64'd0);
    endtask

    task automatic expect_idle(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            check(name, "idle_we",   64'(mem_we), 64'd0);
            check(name, "idle_busy", 64'(busy), 64'd0);
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with mul_done already high: releasing reset must not start an unload.
        rst      = 1'b1;
        mul_done = 1'b1;
        tick();
        tick();
        check("reset", "we",    64'(mem_we), 64'd0);
        check("reset", "busy",  64'(busy), 64'd0);
        check("reset", "done",  64'(unload_done), 64'd0);
        check("reset", "addr",  64'(mem_addr), 64'd0);
        check("reset", "wdata", mem_wdata, 64'd0);
        rst = 1'b0;
        expect_idle("level_after_reset", 4);

        for (int i = 0; i < NC; i++) coef[i] = 13'h1FFF;
        unload("all_ones", -1, 0, -1, -1);

        for (int i = 0; i < NC; i++) coef[i] = i;
        unload("ramp", -1, 0, -1, -1);

        for (int i = 0; i < NC; i++) coef[i] = $urandom_range(0, 8191);
        unload("stall", 5, 3, -1, -1);

        // Glitch of mul_done during write 20, then level held after DONE.
        for (int i = 0; i < NC; i++) coef[i] = $urandom_range(0, 8191);
        unload("retrigger", -1, 0, 21, -1);
        expect_idle("hold_high", 8);

        for (int i = 0; i < NC; i++) coef[i] = $urandom_range(0, 8191);
        unload("rst_mid", -1, 0, -1, 30);
        expect_idle("level_after_midrst", 4);

        for (int i = 0; i < NC; i++) coef[i] = $urandom_range(0, 8191);
        unload("after_rst", -1, 0, -1, -1);

        for (int i = 0; i < NC; i++) coef[i] = 12;
        unload("twelve", -1, 0, -1, -1);

        for (int i = 0; i < NC; i++) coef[i] = $urandom_range(0, 8191);
        unload("random_stall0", 0, 2, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
